compress_block_scheduler: RTL and testbench

//  Parametrised successor to the flat all-blocks-in-parallel compressor top. Instead of one

---
 rtl/compressor_pkg.sv | 8 +
 rtl/compress_block_scheduler_ffs.sv | 20 ++
 rtl/ff_en.sv | 18 +
 rtl/compress_block_scheduler.sv | 130 +++++++++++++
 tb/tb_compress_block_scheduler.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/compressor_pkg.sv
// compressor_pkg: shared types and constants for the tile compression scheduler.
package compressor_pkg;
    localparam int LOG2_BLOCK_SIZE = 3;
    localparam int BLOCK_SIZE      = 1 << LOG2_BLOCK_SIZE;
    localparam int MAX_BLK_ROWS    = 480 / BLOCK_SIZE;
    localparam int MAX_BLK_COLS    = 640 / BLOCK_SIZE;
    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} sched_state_e;
endpackage

// File: rtl/compress_block_scheduler_ffs.sv
// find_first_set: index of the lowest set bit of vec_i, with a valid flag.
module find_first_set #(
    parameter int WIDTH = 4,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ff_en.sv
// ff_en: enabled register with synchronous active-high reset to a parameter value.
module ff_en #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    always_ff @(posedge clk) begin
        if (rst)
            q_o <= RST_VAL;
        else if (en_i)
            q_o <= d_i;
    end
endmodule

// File: rtl/compress_block_scheduler.sv
// compress_block_scheduler: walks image tiles in raster order and time-shares them over
// a pool of compress_block engines, one dispatch per cycle, signalling img_done at the end.
module compress_block_scheduler #(
    parameter int NUM_ENGINES  = 4,
    parameter int MAX_BLK_ROWS = compressor_pkg::MAX_BLK_ROWS,
    parameter int MAX_BLK_COLS = compressor_pkg::MAX_BLK_COLS,
    parameter int ROW_W        = $clog2(MAX_BLK_ROWS),
    parameter int COL_W        = $clog2(MAX_BLK_COLS),
    parameter int CNT_W        = $clog2(MAX_BLK_ROWS * MAX_BLK_COLS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_img,
    input  logic [ROW_W:0]         img_blk_rows,
    input  logic [COL_W:0]         img_blk_cols,
    input  logic [NUM_ENGINES-1:0] eng_done,
    output logic [NUM_ENGINES-1:0] eng_start,
    output logic [ROW_W-1:0]       eng_blk_row,
    output logic [COL_W-1:0]       eng_blk_col,
    output logic                   busy,
    output logic                   img_done,
    output logic [CNT_W-1:0]       blocks_done,
    output logic                   start_ignored,
    output logic                   err_spurious
);
    import compressor_pkg::*;
    localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    sched_state_e           state_q, state_d;
    logic [1:0]             state_raw;
    logic [ROW_W:0]         rows_q, rows_d, n_rows;
    logic [COL_W:0]         cols_q, cols_d, n_cols;
    logic [ROW_W-1:0]       row_cur_q, row_cur_d, cur_row, blk_row_q, blk_row_d;
    logic [COL_W-1:0]       col_cur_q, col_cur_d, cur_col, blk_col_q, blk_col_d;
    logic [NUM_ENGINES-1:0] eng_busy_q, eng_busy_d, eng_start_q, eng_start_d, done_ok;
    logic [CNT_W-1:0]       blocks_q, blocks_d, done_cnt;
    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_valid, accept, zero_dim, do_disp, last_col, last_tile;
    logic                   busy_q, img_done_q, start_ign_q, err_spur_q, err_spur_d;

    find_first_set #(.WIDTH(NUM_ENGINES), .IDX_W(IDX_W)) u_ffs (
        .vec_i  (~eng_busy_q),
        .idx_o  (sel_idx),
        .valid_o(sel_valid)
    );

    ff_en #(.WIDTH(2), .RST_VAL(IDLE)) u_state (
        .clk (clk),
        .rst (rst),
        .en_i(1'b1),
        .d_i (state_d),
        .q_o (state_raw)
    );
    assign state_q = sched_state_e'(state_raw);

    // In IDLE the accepted start dispatches tile (0,0) straight from the input dims.
    always_comb begin
        accept      = start_img && (state_q == IDLE);
        zero_dim    = (img_blk_rows == '0) || (img_blk_cols == '0);
        n_rows      = (state_q == IDLE) ? img_blk_rows : rows_q;
        n_cols      = (state_q == IDLE) ? img_blk_cols : cols_q;
        cur_row     = (state_q == IDLE) ? '0 : row_cur_q;
        cur_col     = (state_q == IDLE) ? '0 : col_cur_q;
        do_disp     = sel_valid && ((state_q == DISPATCH) || (accept && !zero_dim));
        last_col    = ({1'b0, cur_col} + (COL_W+1)'(1)) == n_cols;
        last_tile   = last_col && (({1'b0, cur_row} + (ROW_W+1)'(1)) == n_rows);
        done_ok     = eng_done & eng_busy_q;
        done_cnt    = '0;
        for (int i = 0; i < NUM_ENGINES; i++)
            done_cnt = done_cnt + CNT_W'(done_ok[i]);
        eng_start_d = do_disp ? (NUM_ENGINES'(1) << sel_idx) : '0;
        eng_busy_d  = (eng_busy_q & ~done_ok) | eng_start_d;
        blk_row_d   = do_disp ? cur_row : blk_row_q;
        blk_col_d   = do_disp ? cur_col : blk_col_q;
        row_cur_d   = do_disp ? (last_col ? cur_row + ROW_W'(1) : cur_row) : (accept ? '0 : row_cur_q);
        col_cur_d   = do_disp ? (last_col ? '0 : cur_col + COL_W'(1)) : (accept ? '0 : col_cur_q);
        rows_d      = accept ? img_blk_rows : rows_q;
        cols_d      = accept ? img_blk_cols : cols_q;
        blocks_d    = accept ? '0 : blocks_q + done_cnt;
        err_spur_d  = (accept ? 1'b0 : err_spur_q) | (|(eng_done & ~eng_busy_q));
        state_d     = state_q;
        unique case (state_q)
            IDLE:     if (accept) state_d = zero_dim ? DONE : (do_disp && last_tile) ? DRAIN : DISPATCH;
            DISPATCH: if (do_disp && last_tile) state_d = DRAIN;
            DRAIN:    if (eng_busy_q == '0) state_d = DONE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_q      <= '0;
            cols_q      <= '0;
            row_cur_q   <= '0;
            col_cur_q   <= '0;
            blk_row_q   <= '0;
            blk_col_q   <= '0;
            eng_busy_q  <= '0;
            eng_start_q <= '0;
            blocks_q    <= '0;
            busy_q      <= 1'b0;
            img_done_q  <= 1'b0;
            start_ign_q <= 1'b0;
            err_spur_q  <= 1'b0;
        end else begin
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            row_cur_q   <= row_cur_d;
            col_cur_q   <= col_cur_d;
            blk_row_q   <= blk_row_d;
            blk_col_q   <= blk_col_d;
            eng_busy_q  <= eng_busy_d;
            eng_start_q <= eng_start_d;
            blocks_q    <= blocks_d;
            busy_q      <= state_d != IDLE;
            img_done_q  <= state_q == DONE;
            start_ign_q <= start_img && (state_q != IDLE);
            err_spur_q  <= err_spur_d;
        end
    end

    assign eng_start     = eng_start_q;
    assign eng_blk_row   = blk_row_q;
    assign eng_blk_col   = blk_col_q;
    assign busy          = busy_q;
    assign img_done      = img_done_q;
    assign blocks_done   = blocks_q;
    assign start_ignored = start_ign_q;
    assign err_spurious  = err_spur_q;
endmodule

// File: tb/tb_compress_block_scheduler.sv
// tb_compress_block_scheduler: scoreboard bench with engine responders for the scheduler.
module tb_compress_block_scheduler;
    localparam int NE = 4, ROW_W = 6, COL_W = 7, CNT_W = 13;

    logic                 clk = 1'b0, rst = 1'b1, start_img = 1'b0;
    logic [ROW_W:0]       img_blk_rows = '0;
    logic [COL_W:0]       img_blk_cols = '0;
    logic [NE-1:0]        eng_done, eng_start, resp = '0, inj = '0;
    logic [ROW_W-1:0]     eng_blk_row;
    logic [COL_W-1:0]     eng_blk_col;
    logic                 busy, img_done, start_ignored, err_spurious;
    logic [CNT_W-1:0]     blocks_done;

    assign eng_done = resp | inj;
    always #5 clk = ~clk;

    compress_block_scheduler #(.NUM_ENGINES(NE)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_img    (start_img),
        .img_blk_rows (img_blk_rows),
        .img_blk_cols (img_blk_cols),
        .eng_done     (eng_done),
        .eng_start    (eng_start),
        .eng_blk_row  (eng_blk_row),
        .eng_blk_col  (eng_blk_col),
        .busy         (busy),
        .img_done     (img_done),
        .blocks_done  (blocks_done),
        .start_ignored(start_ignored),
        .err_spurious (err_spurious)
    );

    // Inputs as the DUT saw them at the last rising edge.
    logic           s_rst = 1'b1, s_start = 1'b0;
    logic [ROW_W:0] s_rows = '0;
    logic [COL_W:0] s_cols = '0;
    logic [NE-1:0]  s_done = '0;
    always @(posedge clk) begin
        s_rst   <= rst;
        s_start <= start_img;
        s_rows  <= img_blk_rows;
        s_cols  <= img_blk_cols;
        s_done  <= eng_done;
    end

    int                     checks = 0, failures = 0;
    logic [NE-1:0]          mb = '0, mb_pre, exp_start, ok;
    logic [ROW_W+COL_W-1:0] tq[$];
    logic [ROW_W+COL_W-1:0] tile;
    bit                     m_act = 0, armed = 0, exp_spur = 0, exp_done, accepted, hold = 0;
    int                     cd = -1, exp_blocks = 0, m_rows = 0, m_cols = 0;
    int                     lat = 3, hold_cnt = 0, done_cnt = 0, seen4 = 0;
    int                     timer[NE];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NE-1:0] low_free(input logic [NE-1:0] m);
        for (int i = 0; i < NE; i++)
            if (!m[i]) return NE'(1) << i;
        return '0;
    endfunction

    always @(negedge clk) begin
        if (s_rst) begin
            mb = '0; tq.delete(); m_act = 0; armed = 0; cd = -1;
            exp_blocks = 0; exp_spur = 0; resp = '0;
            for (int k = 0; k < NE; k++) timer[k] = 0;
            chk("rst_eng_start", eng_start, 0);
            chk("rst_busy", busy, 0);
            chk("rst_img_done", img_done, 0);
            chk("rst_blocks", blocks_done, 0);
            chk("rst_ignored", start_ignored, 0);
            chk("rst_spurious", err_spurious, 0);
            chk("rst_rowcol", {eng_blk_row, eng_blk_col}, 0);
        end else begin
            mb_pre   = mb;
            accepted = s_start && !m_act;
            chk("start_ignored", start_ignored, s_start && m_act);
            exp_done = (cd == 0);
            if (cd >= 0) cd--;
            chk("img_done", img_done, exp_done);
            if (exp_done) begin
                m_act = 0;
                done_cnt++;
                chk("blocks_at_done", blocks_done, m_rows * m_cols);
                chk("tiles_left", tq.size(), 0);
            end
            ok = s_done & mb_pre;
            if ($countones(ok) == 4) seen4++;
            if (accepted) begin
                m_act = 1; armed = 0; cd = -1; hold_cnt = 0;
                m_rows = int'(s_rows); m_cols = int'(s_cols);
                exp_blocks = 0;
                exp_spur = |(s_done & ~mb_pre);
                for (int r = 0; r < m_rows; r++)
                    for (int c = 0; c < m_cols; c++)
                        tq.push_back({ROW_W'(r), COL_W'(c)});
                if (m_rows == 0 || m_cols == 0) begin
                    armed = 1;
                    cd = 0;
                end
            end else begin
                exp_blocks += $countones(ok);
                exp_spur |= |(s_done & ~mb_pre);
            end
            exp_start = (tq.size() > 0 && mb_pre != '1) ? low_free(mb_pre) : '0;
            chk("eng_start", eng_start, exp_start);
            if (exp_start != '0) begin
                tile = tq.pop_front();
                chk("tile", {eng_blk_row, eng_blk_col}, tile);
            end
            mb = (mb_pre & ~s_done) | exp_start;
            chk("blocks_done", blocks_done, exp_blocks);
            chk("err_spurious", err_spurious, exp_spur);
            chk("busy", busy, m_act);
            if (m_act && !armed && tq.size() == 0 && mb == '0) begin
                armed = 1;
                cd = 1;
            end
            // Engine responders: fixed latency, or hold everything and release together.
            for (int k = 0; k < NE; k++) begin
                resp[k] = !hold && timer[k] == 1;
                if (timer[k] > 0) timer[k]--;
                if (exp_start[k]) timer[k] = lat;
            end
            if (hold) begin
                hold_cnt++;
                if (hold_cnt % 8 == 7) resp = mb;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic img(input int r, input int c);
        start_img    = 1'b1;
        img_blk_rows = (ROW_W+1)'(r);
        img_blk_cols = (COL_W+1)'(c);
        cyc(1);
        start_img    = 1'b0;
        img_blk_rows = (ROW_W+1)'($urandom_range(1, 9));
        img_blk_cols = (COL_W+1)'($urandom_range(1, 9));
    endtask

    task automatic wait_done();
        int n0 = done_cnt;
        for (int i = 0; i < 2000 && done_cnt == n0; i++) cyc(1);
        chk("wait_img_done", done_cnt != n0, 1);
    endtask

    task automatic run(input int r, input int c);
        img(r, c);
        wait_done();
    endtask

    initial begin
        for (int k = 0; k < NE; k++) timer[k] = 0;
        cyc(3);
        rst = 1'b0;
        cyc(2);
        lat = 3;
        run(2, 2);
        run(1, 3);
        run(0, 5);
        lat = 5;
        img(3, 3);
        cyc(2);
        img(2, 2);
        wait_done();
        inj = 4'b0100;
        cyc(1);
        inj = '0;
        cyc(2);
        chk("spurious_sticky", err_spurious, 1);
        run(1, 2);
        hold = 1;
        run(3, 3);
        hold = 0;
        chk("four_done_same_cycle", seen4 > 0, 1);
        img(4, 4);
        cyc(6);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        run(1, 1);
        chk("images_completed", done_cnt, 7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
